// File: rtl/io_led_controller_pkg.sv
// Shared definitions for the LED/GPIO output controller: bus width, mode
// encodings, register offsets and register field positions.
package io_led_controller_pkg;

  localparam int DATA_W     = 16;
  localparam int BUS_ADDR_W = 16;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_e;

  localparam int OFS_GLOBAL  = 0;
  localparam int OFS_CH_BASE = 1;

  localparam int GLB_EN_BIT   = 0;
  localparam int GLB_RATE_LSB = 1;
  localparam int GLB_RATE_W   = 3;
  localparam int CH_MODE_LSB  = 0;
  localparam int CH_DUTY_LSB  = 8;

endpackage

// File: rtl/io_timebase.sv
// Shared timebase: prescaler producing a tick, a free-running PWM counter and
// a blink counter that advances once per full PWM period.
module io_timebase #(
  parameter int PRESCALE_DIV = 64,
  parameter int PWM_BITS     = 8,
  parameter int BLINK_BITS   = 8
) (
  input  logic                  clock,
  input  logic                  active_high_reset,
  output logic                  tick,
  output logic [PWM_BITS-1:0]   pwm_count,
  output logic [BLINK_BITS-1:0] blink_count
);

  localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [PWM_BITS-1:0]   pwm_q, pwm_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;

  always_comb begin
    tick    = (pre_q == PRE_LAST);
    pre_d   = tick ? '0 : pre_q + 1'b1;
    pwm_d   = tick ? pwm_q + 1'b1 : pwm_q;
    blink_d = (tick && (&pwm_q)) ? blink_q + 1'b1 : blink_q;
  end

  always_ff @(posedge clock) begin
    if (active_high_reset) begin
      pre_q   <= '0;
      pwm_q   <= '0;
      blink_q <= '0;
    end else begin
      pre_q   <= pre_d;
      pwm_q   <= pwm_d;
      blink_q <= blink_d;
    end
  end

  assign pwm_count   = pwm_q;
  assign blink_count = blink_q;

endmodule

// File: rtl/io_led_controller.sv
// Memory-mapped output controller: per-channel OFF/ON/BLINK/PWM modes, a global
// enable with blink rate, a bulk ON/OFF register and registered readback.
module io_led_controller
  import io_led_controller_pkg::*;
#(
  parameter int CHANNELS     = 16,
  parameter int ADDRESS_BITS = 9,
  parameter int BASE_OFFSET  = 0,
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE_DIV = 64,
  parameter int BLINK_BITS   = 8
) (
  input  logic                  clock,
  input  logic                  active_high_reset,
  input  logic                  io_write_enable,
  input  logic                  io_read_enable,
  input  logic [BUS_ADDR_W-1:0] memory_address,
  input  logic [DATA_W-1:0]     data,
  output logic [DATA_W-1:0]     read_data,
  output logic                  read_valid,
  output logic [CHANNELS-1:0]   leds
);

  localparam int BULK_N = (CHANNELS < DATA_W) ? CHANNELS : DATA_W;
  localparam logic [GLB_RATE_W-1:0] RATE_MAX =
    (BLINK_BITS > 8) ? 3'd7 : GLB_RATE_W'(BLINK_BITS - 1);

  logic [ADDRESS_BITS-1:0] offset;
  logic                    hit_global, hit_bulk, wr_global, wr_bulk;
  logic                    tick_unused;
  logic [PWM_BITS-1:0]     pwm_count;
  logic [BLINK_BITS-1:0]   blink_count;

  logic                  en_q, en_d;
  logic [GLB_RATE_W-1:0] rate_q, rate_d, rate_wr;
  logic [DATA_W-1:0]     read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;
  logic [CHANNELS-1:0]   leds_q, leds_d;

  logic [CHANNELS-1:0] term_v, ch_on;
  logic [DATA_W-1:0]   ch_img [CHANNELS];

  assign offset     = memory_address[ADDRESS_BITS-1:0] - ADDRESS_BITS'(BASE_OFFSET);
  assign hit_global = (offset == ADDRESS_BITS'(OFS_GLOBAL));
  assign hit_bulk   = (offset == ADDRESS_BITS'(OFS_CH_BASE + CHANNELS));
  assign wr_global  = io_write_enable & hit_global;
  assign wr_bulk    = io_write_enable & hit_bulk;

  if (ADDRESS_BITS < BUS_ADDR_W) begin : g_addr
    logic [BUS_ADDR_W-1-ADDRESS_BITS:0] addr_unused;
    assign addr_unused = memory_address[BUS_ADDR_W-1:ADDRESS_BITS];
  end

  io_timebase #(
    .PRESCALE_DIV(PRESCALE_DIV),
    .PWM_BITS    (PWM_BITS),
    .BLINK_BITS  (BLINK_BITS)
  ) u_timebase (
    .clock            (clock),
    .active_high_reset(active_high_reset),
    .tick             (tick_unused),
    .pwm_count        (pwm_count),
    .blink_count      (blink_count)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    mode_e               mode_q, mode_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                hit, bulk_en, bulk_bit, term;
    logic [DATA_W-1:0]   img;

    assign hit = (offset == ADDRESS_BITS'(OFS_CH_BASE + i));

    // Channels beyond the bus width are not reachable from the bulk register.
    if (i < BULK_N) begin : g_bulk
      assign bulk_en  = wr_bulk;
      assign bulk_bit = data[i];
    end else begin : g_nobulk
      assign bulk_en  = 1'b0;
      assign bulk_bit = 1'b0;
    end

    always_comb begin
      mode_d = mode_q;
      duty_d = duty_q;
      if (io_write_enable && hit) begin
        mode_d = mode_e'(data[CH_MODE_LSB +: 2]);
        duty_d = data[CH_DUTY_LSB +: PWM_BITS];
      end else if (bulk_en) begin
        mode_d = bulk_bit ? MODE_ON : MODE_OFF;
      end

      term = 1'b0;
      case (mode_q)
        MODE_OFF:   term = 1'b0;
        MODE_ON:    term = 1'b1;
        MODE_BLINK: term = blink_count[rate_q];
        MODE_PWM:   term = (pwm_count < duty_q);
        default:    term = 1'b0;
      endcase

      img = '0;
      img[CH_MODE_LSB +: 2]        = mode_q;
      img[CH_DUTY_LSB +: PWM_BITS] = duty_q;
    end

    always_ff @(posedge clock) begin
      if (active_high_reset) begin
        mode_q <= MODE_OFF;
        duty_q <= '0;
      end else begin
        mode_q <= mode_d;
        duty_q <= duty_d;
      end
    end

    assign term_v[i] = term;
    assign ch_on[i]  = (mode_q == MODE_ON);
    assign ch_img[i] = img;
  end

  always_comb begin
    en_d    = en_q;
    rate_d  = rate_q;
    rate_wr = data[GLB_RATE_LSB +: GLB_RATE_W];
    if (wr_global) begin
      en_d   = data[GLB_EN_BIT];
      rate_d = (rate_wr > RATE_MAX) ? RATE_MAX : rate_wr;
    end

    // Readback uses current register state, so a same-cycle write is not seen.
    read_data_d  = read_data_q;
    read_valid_d = io_read_enable;
    if (io_read_enable) begin
      read_data_d = '0;
      if (hit_global) begin
        read_data_d[GLB_EN_BIT]                  = en_q;
        read_data_d[GLB_RATE_LSB +: GLB_RATE_W] = rate_q;
      end else if (hit_bulk) begin
        read_data_d[BULK_N-1:0] = ch_on[BULK_N-1:0];
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (offset == ADDRESS_BITS'(OFS_CH_BASE + i)) read_data_d = ch_img[i];
        end
      end
    end

    leds_d = {CHANNELS{en_q}} & term_v;
  end

  always_ff @(posedge clock) begin
    if (active_high_reset) begin
      en_q         <= 1'b1;
      rate_q       <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      leds_q       <= '0;
    end else begin
      en_q         <= en_d;
      rate_q       <= rate_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      leds_q       <= leds_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign leds       = leds_q;

endmodule

// File: tb/tb_io_led_controller.sv
// Directed bench for io_led_controller with a fast timebase (one PWM step per clock).
module tb_io_led_controller;

  logic        clock = 1'b0;
  logic        active_high_reset;
  logic        io_write_enable;
  logic        io_read_enable;
  logic [15:0] memory_address;
  logic [15:0] data;
  logic [15:0] read_data;
  logic        read_valid;
  logic [15:0] leds;

  int n_checks = 0;
  int n_fail   = 0;

  io_led_controller #(
    .CHANNELS    (16),
    .ADDRESS_BITS(9),
    .BASE_OFFSET (0),
    .PWM_BITS    (8),
    .PRESCALE_DIV(1),
    .BLINK_BITS  (8)
  ) dut (
    .clock            (clock),
    .active_high_reset(active_high_reset),
    .io_write_enable  (io_write_enable),
    .io_read_enable   (io_read_enable),
    .memory_address   (memory_address),
    .data             (data),
    .read_data        (read_data),
    .read_valid       (read_valid),
    .leds             (leds)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    memory_address  = a;
    data            = d;
    io_write_enable = 1'b1;
    step();
    io_write_enable = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
    memory_address = a;
    io_read_enable = 1'b1;
    step();
    io_read_enable = 1'b0;
    check_eq({tag, "_vld"}, {31'd0, read_valid}, 32'd1);
    check_eq(tag, {16'd0, read_data}, {16'd0, exp});
  endtask

  task automatic count_high(input int bit_i, output int highs);
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (leds[bit_i]) highs++;
    end
  endtask

  // Waits for a transition on one LED, then returns the cycles to the next one (-1 on timeout).
  task automatic measure_period(input int bit_i, input int limit, output int period);
    logic prev;
    int   cnt;
    bit   seen;
    period = -1;
    seen   = 1'b0;
    prev   = leds[bit_i];
    for (int k = 0; k < limit && !seen; k++) begin
      step();
      if (leds[bit_i] != prev) seen = 1'b1;
    end
    if (seen) begin
      prev = leds[bit_i];
      cnt  = 0;
      seen = 1'b0;
      for (int k = 0; k < limit && !seen; k++) begin
        step();
        cnt++;
        if (leds[bit_i] != prev) seen = 1'b1;
      end
      if (seen) period = cnt;
    end
  endtask

  int highs;
  int period;

  initial begin
    active_high_reset = 1'b1;
    io_write_enable   = 1'b1;
    io_read_enable    = 1'b0;
    memory_address    = 16'd4;
    data              = 16'h0001;
    step_n(2);
    check_eq("rst_leds", {16'd0, leds}, 32'd0);
    check_eq("rst_rvld", {31'd0, read_valid}, 32'd0);
    active_high_reset = 1'b0;
    io_write_enable   = 1'b0;
    bus_read("rst_global", 16'd0, 16'h0001);
    step();
    check_eq("rvld_one_cycle", {31'd0, read_valid}, 32'd0);
    bus_read("rst_ch3", 16'd4, 16'h0000);

    bus_write(16'd4, 16'h0001);
    check_eq("ch3_latency", {16'd0, leds}, 32'd0);
    step();
    check_eq("ch3_on", {16'd0, leds}, 32'h0008);

    bus_write(16'd17, 16'hA5A5);
    step();
    check_eq("bulk_leds", {16'd0, leds}, 32'hA5A5);
    bus_read("bulk_rd", 16'd17, 16'hA5A5);
    bus_read("ch3_after_bulk", 16'd4, 16'h0000);

    bus_write(16'd0, 16'h0000);
    check_eq("gdis_latency", {16'd0, leds}, 32'hA5A5);
    step();
    check_eq("gdis_leds", {16'd0, leds}, 32'h0000);
    bus_write(16'd0, 16'h0001);
    step();
    check_eq("gen_restore", {16'd0, leds}, 32'hA5A5);
    bus_read("gen_ch0", 16'd1, 16'h0001);
    bus_read("gen_ch1", 16'd2, 16'h0000);

    bus_write(16'd17, 16'h0000);
    bus_write(16'd1, 16'h4003);
    step_n(2);
    count_high(0, highs);
    check_eq("pwm64", highs, 64);
    bus_write(16'd1, 16'h0003);
    step_n(2);
    count_high(0, highs);
    check_eq("pwm0", highs, 0);
    bus_write(16'd1, 16'hFF03);
    step_n(2);
    count_high(0, highs);
    check_eq("pwm255", highs, 255);
    bus_read("pwm_ch0_rd", 16'd1, 16'hFF03);

    bus_write(16'd6, 16'h0002);
    step_n(2);
    measure_period(5, 600, period);
    check_eq("blink_r0", period, 256);
    bus_write(16'd0, 16'h0005);
    step_n(2);
    measure_period(5, 1100, period);
    check_eq("blink_r2", period, 1024);

    bus_write(16'd1, 16'h0000);
    bus_write(16'd6, 16'h0000);
    bus_write(16'd17, 16'h0F0F);
    bus_write(16'd18, 16'hFFFF);
    bus_write(16'h01FF, 16'hFFFF);
    step();
    check_eq("bad_ofs_leds", {16'd0, leds}, 32'h0F0F);
    bus_read("bad_ofs_global", 16'd0, 16'h0005);
    bus_read("rd_ofs18", 16'd18, 16'h0000);
    bus_read("rd_ofs1ff", 16'h01FF, 16'h0000);
    bus_read("bad_ofs_bulk", 16'd17, 16'h0F0F);

    bus_write(16'd2, 16'h1201);
    memory_address  = 16'd2;
    data            = 16'h0000;
    io_write_enable = 1'b1;
    io_read_enable  = 1'b1;
    step();
    io_write_enable = 1'b0;
    io_read_enable  = 1'b0;
    check_eq("rw_old", {16'd0, read_data}, 32'h1201);
    bus_read("rw_new", 16'd2, 16'h0000);

    bus_write(16'd1, 16'h4003);
    step_n(10);
    active_high_reset = 1'b1;
    memory_address    = 16'd2;
    data              = 16'h0001;
    io_write_enable   = 1'b1;
    step();
    check_eq("midrst_leds", {16'd0, leds}, 32'd0);
    active_high_reset = 1'b0;
    io_write_enable   = 1'b0;
    bus_write(16'd1, 16'h4003);
    step_n(63);
    check_eq("midrst_pwm_hi", {31'd0, leds[0]}, 32'd1);
    step();
    check_eq("midrst_pwm_lo", {31'd0, leds[0]}, 32'd0);
    bus_read("midrst_ch1", 16'd2, 16'h0000);
    bus_read("midrst_global", 16'd0, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_led_controller.md
Name: io_led_controller

Overview:
- Parametrised successor to the single-bit LED write port: a memory-mapped output controller for CHANNELS channels.
- Each channel has its own mode: OFF, ON, BLINK or PWM brightness.
- Adds a global enable, a bulk level register, register readback and a shared timebase.
- Sits on the CPU io bus beside the memory; drives board LEDs or GPIO pins through a registered output vector.

Parameters:
- CHANNELS, 16, number of output channels (1..32; bulk register covers min(CHANNELS, `WIDTH) channels).
- ADDRESS_BITS, 9, low address bits decoded from memory_address.
- BASE_OFFSET, 0, decode window start within the ADDRESS_BITS space.
- PWM_BITS, 8, duty/PWM counter width (must be ≤ `WIDTH-8).
- PRESCALE_DIV, 64, clocks per PWM tick (≥ 1).
- BLINK_BITS, 8, blink divider counter width.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- active_high_reset  in  1  synchronous, active-high reset.
- io_write_enable  in  1  write strobe, one cycle per write.
- io_read_enable  in  1  read strobe, one cycle per read.
- memory_address  in  16  bus address; only [ADDRESS_BITS-1:0] decoded.
- data  in  `WIDTH  write data.
- read_data  out  `WIDTH  readback data.
- read_valid  out  1  readback qualifier.
- leds  out  CHANNELS  registered channel outputs.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: all channel modes OFF, all duties 0, GLOBAL = enable 1 / rate 0, prescaler, PWM and blink counters 0, leds 0, read_data 0, read_valid 0.
- Address map, offset = memory_address[ADDRESS_BITS-1:0] - BASE_OFFSET:
  - offset 0: GLOBAL. Bit0 is the global enable. Bits[3:1] are the blink rate select r, clamped to BLINK_BITS-1.
  - offset 1..CHANNELS: CHn for n = offset-1. Bits[1:0] are the mode (00 OFF, 01 ON, 10 BLINK, 11 PWM). Bits[8+PWM_BITS-1:8] are the duty.
  - offset CHANNELS+1: BULK. A write sets mode of channel i to data[i] ? ON : OFF for every i < min(CHANNELS, `WIDTH). Channels outside that range and all duty fields are unchanged.
  - Any other offset: writes ignored, reads return 0.
- Writes: take effect at the rising edge where io_write_enable=1. Unused data bits are ignored.
- Reads: 1-cycle latency. read_data and read_valid are registered at the edge after io_read_enable.
  - read_valid is high for exactly one cycle per read strobe.
  - read_data returns the register image with unused bits 0. BULK reads back the current ON/OFF status bit of each channel.
- Simultaneous read and write to the same offset: the read returns the pre-write value.
- Timebase:
  - The prescaler counts 0..PRESCALE_DIV-1 and pulses tick on its wrap.
  - pwm_count (PWM_BITS) increments on tick and wraps naturally.
  - blink_count (BLINK_BITS) increments on tick when pwm_count wraps (all-ones -> 0).
  - Counters run regardless of the global enable.
- Channel output term per mode:
  - OFF = 0.
  - ON = 1.
  - BLINK = blink_count[r].
  - PWM = (pwm_count < duty). Duty 0 gives constant 0; all-ones duty gives high for 2^PWM_BITS-1 of 2^PWM_BITS ticks.
- Output register: leds[n] <= enable & term(n) every clock. A write at edge N is visible on leds after edge N+1.
- Clearing the global enable forces leds to 0 one cycle later. Channel registers and counters are preserved.
- Reset asserted mid-operation: state returns to the reset values at the next edge, overriding any concurrent write or read.

Decomposition:
- Shared header io_defs.h holds: mode encodings (IO_MODE_OFF/ON/BLINK/PWM), register offsets for GLOBAL and CHn base, and the field bit positions.
- `WIDTH stays in common.h.
- Sub-module io_timebase: contains the prescaler, pwm_count and blink_count. Outputs are tick, pwm_count and blink_count; parameters are PRESCALE_DIV, PWM_BITS and BLINK_BITS.
- Per-channel mode mux and address decode live in io_led_controller using a generate loop.

Test Plan:
- Reset: hold active_high_reset 2 cycles with io_write_enable=1 -> leds=0, read_valid=0; then read offset 0 -> read_data=0x0001, read_valid high exactly one cycle later.
- Static write: write CH3 (offset 4) data=0x0001 at edge N -> leds[3]=1 after edge N+1, others 0. Write BULK data=0xA5A5 -> leds=0xA5A5 two edges later; read BULK returns 0xA5A5.
- PWM, with PRESCALE_DIV=1, PWM_BITS=8: CH0 mode PWM duty 64 -> leds[0] high for exactly 64 of every 256 cycles. Duty 0 -> always 0. Duty 255 -> low exactly 1 cycle per 256.
- Blink, with PRESCALE_DIV=1, r=0: CH5 BLINK -> leds[5] toggles every 256 cycles. Write GLOBAL rate 2 -> toggles every 1024 cycles.
- Global enable: several channels ON, write GLOBAL=0 -> leds=0 next cycle. Write GLOBAL=1 -> previous pattern restored; CH readbacks unchanged.
- Edge cases:
  - Write to offset CHANNELS+2 and to offset 0x1FF -> no state change; reads return 0.
  - Same-cycle read+write to CH1 -> old value returned.
  - Reset asserted mid-PWM -> leds=0 and pwm_count restarts from 0.
